// File: rtl/uart_transmitter.sv
// UART transmitter: start bit, N data bits LSB first, optional parity, stop period.
// Bit timing comes from the shared oversampling strobe; all outputs are registered.
module uart_transmitter #(
   parameter int unsigned N          = 8,
   parameter int unsigned OVERSAMPLE = 16,
   parameter int unsigned SB_TICK    = 16,
   parameter int unsigned PARITY_EN  = 0,
   parameter int unsigned PARITY_ODD = 0
) (
   input  logic         clk,
   input  logic         rst,
   input  logic         tx_start,
   input  logic         sample_tick,
   input  logic [N-1:0] din,
   output logic         tx,
   output logic         busy,
   output logic         tx_done
);

   localparam int unsigned TickMax = (OVERSAMPLE > SB_TICK) ? OVERSAMPLE : SB_TICK;
   localparam int unsigned TickW   = (TickMax > 1) ? $clog2(TickMax) : 1;
   localparam int unsigned BitW    = (N > 1) ? $clog2(N) : 1;

   localparam logic [TickW-1:0] BitLast  = TickW'(OVERSAMPLE - 1);
   localparam logic [TickW-1:0] StopLast = TickW'(SB_TICK - 1);
   localparam logic [BitW-1:0]  DataLast = BitW'(N - 1);
   localparam logic             OddPar   = (PARITY_ODD != 0);

   typedef enum logic [2:0] {StIdle, StStart, StData, StParity, StStop} state_e;

   state_e           state_q;
   logic [TickW-1:0] tick_q;
   logic [BitW-1:0]  bit_q;
   logic [N-1:0]     shift_q;
   logic             parity_q;

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q  <= StIdle;
         tick_q   <= '0;
         bit_q    <= '0;
         shift_q  <= '0;
         parity_q <= 1'b0;
         tx       <= 1'b1;
         busy     <= 1'b0;
         tx_done  <= 1'b0;
      end else begin
         tx_done <= 1'b0;
         case (state_q)
            StIdle: begin
               tx   <= 1'b1;
               busy <= 1'b0;
               // A tick on the acceptance edge is deliberately not counted.
               if (tx_start) begin
                  shift_q  <= din;
                  parity_q <= (^din) ^ OddPar;
                  tick_q   <= '0;
                  bit_q    <= '0;
                  tx       <= 1'b0;
                  busy     <= 1'b1;
                  state_q  <= StStart;
               end
            end
            StStart: begin
               if (sample_tick) begin
                  if (tick_q == BitLast) begin
                     tick_q  <= '0;
                     bit_q   <= '0;
                     tx      <= shift_q[0];
                     state_q <= StData;
                  end else begin
                     tick_q <= tick_q + 1'b1;
                  end
               end
            end
            StData: begin
               if (sample_tick) begin
                  if (tick_q == BitLast) begin
                     tick_q <= '0;
                     if (bit_q == DataLast) begin
                        if (PARITY_EN != 0) begin
                           tx      <= parity_q;
                           state_q <= StParity;
                        end else begin
                           tx      <= 1'b1;
                           state_q <= StStop;
                        end
                     end else begin
                        bit_q   <= bit_q + 1'b1;
                        shift_q <= shift_q >> 1;
                        tx      <= shift_q[1];
                     end
                  end else begin
                     tick_q <= tick_q + 1'b1;
                  end
               end
            end
            StParity: begin
               if (sample_tick) begin
                  if (tick_q == BitLast) begin
                     tick_q  <= '0;
                     tx      <= 1'b1;
                     state_q <= StStop;
                  end else begin
                     tick_q <= tick_q + 1'b1;
                  end
               end
            end
            StStop: begin
               tx <= 1'b1;
               if (sample_tick) begin
                  if (tick_q == StopLast) begin
                     tick_q  <= '0;
                     busy    <= 1'b0;
                     tx_done <= 1'b1;
                     state_q <= StIdle;
                  end else begin
                     tick_q <= tick_q + 1'b1;
                  end
               end
            end
            default: begin
               tx      <= 1'b1;
               busy    <= 1'b0;
               state_q <= StIdle;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_uart_transmitter.sv
// Directed bench for uart_transmitter: four instances cover plain, even/odd parity
// and 2-stop-bit framing; a behavioural receiver checks the loopback instance.
module tb_uart_transmitter;

   logic       clk;
   logic       rst;
   logic       sample_tick;
   logic [7:0] din;
   logic [3:0] tx_start_v;
   logic [3:0] tx_v;
   logic [3:0] busy_v;
   logic [3:0] done_v;
   logic [1:0] tick_div;

   int checks = 0;
   int errors = 0;

   uart_transmitter #(.N(8), .OVERSAMPLE(16), .SB_TICK(16), .PARITY_EN(0), .PARITY_ODD(0)) u_plain (
      .clk(clk), .rst(rst), .tx_start(tx_start_v[0]), .sample_tick(sample_tick), .din(din),
      .tx(tx_v[0]), .busy(busy_v[0]), .tx_done(done_v[0]));
   uart_transmitter #(.N(8), .OVERSAMPLE(16), .SB_TICK(16), .PARITY_EN(1), .PARITY_ODD(0)) u_even (
      .clk(clk), .rst(rst), .tx_start(tx_start_v[1]), .sample_tick(sample_tick), .din(din),
      .tx(tx_v[1]), .busy(busy_v[1]), .tx_done(done_v[1]));
   uart_transmitter #(.N(8), .OVERSAMPLE(16), .SB_TICK(16), .PARITY_EN(1), .PARITY_ODD(1)) u_odd (
      .clk(clk), .rst(rst), .tx_start(tx_start_v[2]), .sample_tick(sample_tick), .din(din),
      .tx(tx_v[2]), .busy(busy_v[2]), .tx_done(done_v[2]));
   uart_transmitter #(.N(8), .OVERSAMPLE(16), .SB_TICK(32), .PARITY_EN(0), .PARITY_ODD(0)) u_loop (
      .clk(clk), .rst(rst), .tx_start(tx_start_v[3]), .sample_tick(sample_tick), .din(din),
      .tx(tx_v[3]), .busy(busy_v[3]), .tx_done(done_v[3]));

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   // One-clk strobe every 4 clks, changed 2 time units after the rising edge.
   initial begin
      sample_tick = 1'b0;
      tick_div    = 2'd0;
      forever begin
         @(posedge clk);
         #2;
         tick_div    = tick_div + 2'd1;
         sample_tick = (tick_div == 2'd0);
      end
   end

   // Called at the negedge right after the acceptance edge; returns at the tx_done negedge.
   task automatic run_frame(input int s, input logic [7:0] data, input int pe, input logic par,
                            input int sbt, input int inject, input string name);
      int   k = 0;
      int   cyc = 0;
      int   total;
      int   b;
      int   inj = 0;
      int   busy_bad = 0;
      int   done_early = 0;
      logic exp_bit;
      logic ticked;
      total = (9 + pe) * 16 + sbt;
      checks++;
      if (tx_v[s] !== 1'b0 || busy_v[s] !== 1'b1) begin
         errors++;
         $display("FAIL %s start: tx=%b busy=%b expected tx=0 busy=1", name, tx_v[s], busy_v[s]);
      end
      while (k < total && cyc < 20000) begin
         if (inject >= 0 && k == inject && inj == 0) begin
            din           = 8'h3C;
            tx_start_v[s] = 1'b1;
            inj           = 1;
         end else if (inj == 1) begin
            tx_start_v[s] = 1'b0;
            inj           = 2;
         end
         ticked = sample_tick;
         if (ticked) k++;
         @(negedge clk);
         cyc++;
         if (ticked && (k % 16) == 8) begin
            b = k / 16;
            if (b == 0) exp_bit = 1'b0;
            else if (b <= 8) exp_bit = data[b-1];
            else if (b == 9 && pe != 0) exp_bit = par;
            else exp_bit = 1'b1;
            checks++;
            if (tx_v[s] !== exp_bit) begin
               errors++;
               $display("FAIL %s bit%0d: tx=%b expected %b", name, b, tx_v[s], exp_bit);
            end
         end
         if (k < total) begin
            if (busy_v[s] !== 1'b1) busy_bad++;
            if (done_v[s] !== 1'b0) done_early++;
         end
      end
      checks++;
      if (k != total) begin
         errors++;
         $display("FAIL %s length: ticks=%0d expected %0d (cycle budget ran out)", name, k, total);
      end
      checks++;
      if (busy_bad != 0 || done_early != 0) begin
         errors++;
         $display("FAIL %s in-frame: busy low %0d clks, early tx_done %0d clks expected 0/0",
                  name, busy_bad, done_early);
      end
      checks++;
      if (done_v[s] !== 1'b1 || busy_v[s] !== 1'b0 || tx_v[s] !== 1'b1) begin
         errors++;
         $display("FAIL %s end: tx_done=%b busy=%b tx=%b expected 1/0/1",
                  name, done_v[s], busy_v[s], tx_v[s]);
      end
   endtask

   task automatic launch(input int s, input logic [7:0] data);
      din           = data;
      tx_start_v[s] = 1'b1;
      @(negedge clk);
      tx_start_v[s] = 1'b0;
   endtask

   task automatic test_reset();
      rst        = 1'b1;
      tx_start_v = 4'b0;
      din        = 8'h00;
      repeat (3) @(negedge clk);
      checks++;
      if (tx_v !== 4'hF || busy_v !== 4'h0 || done_v !== 4'h0) begin
         errors++;
         $display("FAIL reset: tx=%b busy=%b tx_done=%b expected 1111/0000/0000",
                  tx_v, busy_v, done_v);
      end
      rst = 1'b0;
      repeat (20) @(negedge clk);
      checks++;
      if (tx_v !== 4'hF || busy_v !== 4'h0 || done_v !== 4'h0) begin
         errors++;
         $display("FAIL idle ticks: tx=%b busy=%b tx_done=%b expected 1111/0000/0000",
                  tx_v, busy_v, done_v);
      end
   endtask

   task automatic test_basic();
      launch(0, 8'hA5);
      run_frame(0, 8'hA5, 0, 1'b0, 16, -1, "basic_a5");
      @(negedge clk);
      checks++;
      if (done_v[0] !== 1'b0 || busy_v[0] !== 1'b0) begin
         errors++;
         $display("FAIL basic pulse: tx_done=%b busy=%b expected 0/0", done_v[0], busy_v[0]);
      end
   endtask

   task automatic test_parity();
      launch(1, 8'hA5);
      run_frame(1, 8'hA5, 1, 1'b0, 16, -1, "even_a5");
      @(negedge clk);
      launch(2, 8'h07);
      run_frame(2, 8'h07, 1, 1'b0, 16, -1, "odd_07");
      @(negedge clk);
      launch(1, 8'h01);
      run_frame(1, 8'h01, 1, 1'b1, 16, -1, "even_01");
      @(negedge clk);
   endtask

   task automatic test_busy_reject();
      int extra = 0;
      launch(0, 8'hA5);
      run_frame(0, 8'hA5, 0, 1'b0, 16, 40, "reject_a5");
      repeat (200) begin
         @(negedge clk);
         if (busy_v[0] !== 1'b0 || done_v[0] !== 1'b0 || tx_v[0] !== 1'b1) extra++;
      end
      checks++;
      if (extra != 0) begin
         errors++;
         $display("FAIL reject after: %0d non-idle clks expected 0", extra);
      end
   endtask

   task automatic test_back_to_back();
      din           = 8'h55;
      tx_start_v[0] = 1'b1;
      @(negedge clk);
      din = 8'hAA;
      run_frame(0, 8'h55, 0, 1'b0, 16, -1, "b2b_55");
      @(negedge clk);
      din = 8'h00;
      run_frame(0, 8'hAA, 0, 1'b0, 16, -1, "b2b_aa");
      tx_start_v[0] = 1'b0;
      @(negedge clk);
   endtask

   task automatic test_reset_mid();
      int k = 0;
      int cyc = 0;
      launch(0, 8'hA5);
      while (k < 72 && cyc < 2000) begin
         if (sample_tick) k++;
         @(negedge clk);
         cyc++;
      end
      checks++;
      if (busy_v[0] !== 1'b1) begin
         errors++;
         $display("FAIL reset_mid pre: busy=%b expected 1", busy_v[0]);
      end
      rst           = 1'b1;
      din           = 8'h3C;
      tx_start_v[0] = 1'b1;
      @(negedge clk);
      checks++;
      if (tx_v[0] !== 1'b1 || busy_v[0] !== 1'b0 || done_v[0] !== 1'b0) begin
         errors++;
         $display("FAIL reset_mid: tx=%b busy=%b tx_done=%b expected 1/0/0",
                  tx_v[0], busy_v[0], done_v[0]);
      end
      rst           = 1'b0;
      tx_start_v[0] = 1'b0;
      @(negedge clk);
      checks++;
      if (tx_v[0] !== 1'b1 || busy_v[0] !== 1'b0) begin
         errors++;
         $display("FAIL reset_mid drop: tx=%b busy=%b expected 1/0", tx_v[0], busy_v[0]);
      end
      launch(0, 8'hF0);
      run_frame(0, 8'hF0, 0, 1'b0, 16, -1, "after_reset_f0");
      @(negedge clk);
   endtask

   // Behavioural receiver: mid-bit sampling 8 + 16*(i+1) ticks after the falling edge.
   task automatic rx_model(output logic [7:0] d, output logic stop_bit, output int rx_done);
      int t = 0;
      int cyc = 0;
      d        = 8'h00;
      stop_bit = 1'b0;
      rx_done  = 0;
      do begin
         @(posedge clk);
         #1;
         cyc++;
      end while (tx_v[3] !== 1'b0 && cyc < 1000);
      while (t < 152 && cyc < 20000) begin
         @(posedge clk);
         #1;
         cyc++;
         if (sample_tick) begin
            t++;
            if (t >= 24 && t <= 136 && ((t - 24) % 16) == 0) d[(t-24)/16] = tx_v[3];
            if (t == 152) begin
               stop_bit = tx_v[3];
               rx_done++;
            end
         end
      end
   endtask

   task automatic test_loopback();
      logic [7:0] vals [3];
      logic [7:0] dout;
      logic       stop_bit;
      int         rx_done;
      int         cyc;
      vals[0] = 8'h00;
      vals[1] = 8'hFF;
      vals[2] = 8'h81;
      for (int i = 0; i < 3; i++) begin
         din           = vals[i];
         tx_start_v[3] = 1'b1;
         @(negedge clk);
         tx_start_v[3] = 1'b0;
         rx_model(dout, stop_bit, rx_done);
         checks++;
         if (dout !== vals[i] || stop_bit !== 1'b1 || rx_done != 1) begin
            errors++;
            $display("FAIL loopback %0d: dout=%h stop=%b rx_done=%0d expected %h/1/1",
                     i, dout, stop_bit, rx_done, vals[i]);
         end
         cyc = 0;
         while (done_v[3] !== 1'b1 && cyc < 400) begin
            @(posedge clk);
            #1;
            cyc++;
         end
         checks++;
         if (done_v[3] !== 1'b1 || busy_v[3] !== 1'b0) begin
            errors++;
            $display("FAIL loopback done %0d: tx_done=%b busy=%b expected 1/0",
                     i, done_v[3], busy_v[3]);
         end
         @(negedge clk);
         @(negedge clk);
      end
   endtask

   initial begin
      test_reset();
      test_basic();
      test_parity();
      test_busy_reject();
      test_back_to_back();
      test_reset_mid();
      test_loopback();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
